// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply (shift-add) and restoring divide with HI/LO; divide built only with MDU_DIV_EN.
// Latency: start at E0, HI/LO written and done pulsed at E33; MTHI/MTLO write on the accepting edge.
// Backpressure: busy while in flight, start ignored when busy; flush aborts with no HI/LO write.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic              flush,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    logic [1:0]          state;
    logic [4:0]          cnt;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic                neg_lo;

    logic                is_mul_op;
    logic                is_div_op;
    logic                is_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [2*DATA_W-1:0] prod_fix;

    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
`else
    assign is_div_op = 1'b0;
`endif
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & rs_val[DATA_W-1];
    assign b_neg     = is_signed & rt_val[DATA_W-1];
    assign a_mag     = a_neg ? -rs_val : rs_val;
    assign b_mag     = b_neg ? -rt_val : rt_val;

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out LSB-first.
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};
    assign prod_fix = neg_lo ? -acc : acc;

    assign busy = (state != ST_IDLE);

`ifdef MDU_DIV_EN
    logic              is_div;
    logic              neg_hi;
    logic              dz_pend;
    logic [DATA_W-1:0] rem;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_diff;
    logic              rem_ge;
    logic [DATA_W-1:0] rem_src;
    logic [DATA_W-1:0] div_hi;
    logic [DATA_W-1:0] div_lo;

    // Divisor sits in mcand; the dividend shifts out of acc's low half as quotient bits shift in.
    assign rem_shift = {rem, acc[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, mcand};
    assign rem_ge    = ~rem_diff[DATA_W];
    // A zero divisor freezes the datapath so acc still holds |A| for the HI result.
    assign rem_src   = dz_pend ? acc[DATA_W-1:0] : rem;
    assign div_hi    = neg_hi ? -rem_src : rem_src;
    assign div_lo    = dz_pend ? '1 : (neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mcand    <= '0;
            acc      <= '0;
            neg_lo   <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MDU_DIV_EN
            is_div   <= 1'b0;
            neg_hi   <= 1'b0;
            dz_pend  <= 1'b0;
            rem      <= '0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (is_mul_op || is_div_op) begin
                            mcand  <= is_div_op ? b_mag : a_mag;
                            acc    <= {{DATA_W{1'b0}}, (is_div_op ? a_mag : b_mag)};
                            neg_lo <= a_neg ^ b_neg;
                            cnt    <= '0;
                            state  <= ST_ITER;
`ifdef MDU_DIV_EN
                            is_div  <= is_div_op;
                            neg_hi  <= a_neg;
                            dz_pend <= (rt_val == '0);
                            rem     <= '0;
`endif
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                ST_ITER: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
`ifdef MDU_DIV_EN
                        if (is_div) begin
                            if (!dz_pend) begin
                                rem <= rem_ge ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
                                acc[DATA_W-1:0] <= {acc[DATA_W-2:0], rem_ge};
                            end
                        end else
`endif
                        acc <= mul_next;
                        if (cnt == 5'd31) begin
                            state <= ST_FIX;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        done <= 1'b1;
`ifdef MDU_DIV_EN
                        if (is_div) begin
                            hi       <= div_hi;
                            lo       <= div_lo;
                            div_zero <= dz_pend;
                        end else begin
                            div_zero <= 1'b0;
`else
                        begin
`endif
                            hi <= prod_fix[2*DATA_W-1:DATA_W];
                            lo <= prod_fix[DATA_W-1:0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
